// File: rtl/seven_seg_scanner_pkg.sv
// rtl/seven_seg_scanner_pkg.sv - glyph constants, slot indices and score record for the scanner
package seven_seg_scanner_pkg;

    localparam logic [1:0] SLOT_ONES     = 2'd0;
    localparam logic [1:0] SLOT_TENS     = 2'd1;
    localparam logic [1:0] SLOT_HUNDREDS = 2'd2;
    localparam logic [1:0] SLOT_TAG      = 2'd3;

    // Active-high {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_TAG_A = 7'h77;
    localparam logic [6:0] GLYPH_TAG_B = 7'h7C;
    localparam logic [6:0] SEG_BLANK   = 7'h00;

    typedef struct packed {
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       team_sel;
    } score_t;

endpackage

// File: rtl/seven_seg_scanner_bcd_to_seven_seg.sv
// rtl/seven_seg_scanner_bcd_to_seven_seg.sv - BCD digit to active-high segment pattern, dash for >9
module bcd_to_seven_seg
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = GLYPH_DASH;
        case (digit_i)
            4'd0:    seg_o = GLYPH_0;
            4'd1:    seg_o = GLYPH_1;
            4'd2:    seg_o = GLYPH_2;
            4'd3:    seg_o = GLYPH_3;
            4'd4:    seg_o = GLYPH_4;
            4'd5:    seg_o = GLYPH_5;
            4'd6:    seg_o = GLYPH_6;
            4'd7:    seg_o = GLYPH_7;
            4'd8:    seg_o = GLYPH_8;
            4'd9:    seg_o = GLYPH_9;
            default: seg_o = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - 4-digit multiplexed score display with frame-synchronised load and blink
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_TICKS = 250,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       team_sel,
    input  logic       blink_en,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;

    logic [PW-1:0] pre_q;
    logic [1:0]    idx_q;
    logic          tick;
    logic          wrap_tick;
    logic          wrap_q;
    logic          frame_q;

    score_t        load_val;
    score_t        pend_q;
    score_t        disp_q;
    logic          pend_valid_q;

    logic [BW-1:0] blink_cnt_q;
    logic          blink_off_q;

    logic [3:0]    digit_sel;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_act;
    logic [3:0]    an_act;
    logic          slot_blank;
    logic [6:0]    seg_d;
    logic [3:0]    an_d;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;

    assign tick      = (pre_q == PW'(REFRESH_DIV - 1));
    assign wrap_tick = tick && (idx_q == SLOT_TAG);
    assign load_val  = {hundreds, tens, ones, team_sel};

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            idx_q   <= SLOT_ONES;
            wrap_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            pre_q   <= tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                idx_q <= idx_q + 2'd1;
            end
            wrap_q  <= wrap_tick;
            frame_q <= wrap_q;
        end
    end

    // New scores only reach the display register at the frame boundary, so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            disp_q       <= '0;
        end else if (load && wrap_tick) begin
            disp_q       <= load_val;
            pend_valid_q <= 1'b0;
        end else begin
            if (wrap_tick && pend_valid_q) begin
                disp_q       <= pend_q;
                pend_valid_q <= 1'b0;
            end
            if (load) begin
                pend_q       <= load_val;
                pend_valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !blink_en) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                blink_cnt_q <= '0;
                blink_off_q <= ~blink_off_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
        end
    end

    bcd_to_seven_seg u_dec (
        .digit_i (digit_sel),
        .seg_o   (dec_seg)
    );

    always_comb begin
        digit_sel  = disp_q.ones;
        slot_blank = 1'b0;
        case (idx_q)
            SLOT_TENS: begin
                digit_sel  = disp_q.tens;
                slot_blank = (disp_q.hundreds == 4'd0) && (disp_q.tens == 4'd0);
            end
            SLOT_HUNDREDS: begin
                digit_sel  = disp_q.hundreds;
                slot_blank = (disp_q.hundreds == 4'd0);
            end
            default: digit_sel = disp_q.ones;
        endcase

        seg_act = dec_seg;
        if (idx_q == SLOT_TAG) begin
            seg_act = disp_q.team_sel ? GLYPH_TAG_B : GLYPH_TAG_A;
        end
        an_act = 4'b0001 << idx_q;

        // blink_en gates directly so dropping it restores the display on the next edge
        if (slot_blank || (blink_en && blink_off_q)) begin
            seg_act = SEG_BLANK;
            an_act  = 4'b0000;
        end

        seg_d = ACTIVE_LOW ? ~seg_act : seg_act;
        an_d  = ACTIVE_LOW ? ~an_act  : an_act;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       team_sel;
    logic       blink_en;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_start;

    int checks   = 0;
    int failures = 0;
    int n        = 0;
    int viol;
    int frames;
    int offcnt;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .REFRESH_DIV (4),
        .BLINK_TICKS (8),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .hundreds    (hundreds),
        .tens        (tens),
        .ones        (ones),
        .team_sel    (team_sel),
        .blink_en    (blink_en),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_an(input string tag, input logic [3:0] exp);
        chk(tag, {4'b0, an}, {4'b0, exp});
    endtask

    task automatic chk_seg(input string tag, input logic [6:0] glyph);
        logic [6:0] inv;
        inv = ~glyph;
        chk(tag, {1'b0, seg}, {1'b0, inv});
    endtask

    task automatic chk_frame(input string tag, input logic exp);
        chk(tag, {7'b0, frame_start}, {7'b0, exp});
    endtask

    task automatic goto(input int target);
        while (n < target) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o, input logic tm);
        hundreds = h;
        tens     = t;
        ones     = o;
        team_sel = tm;
        load     = 1'b1;
        goto(n + 1);
        load     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; hundreds = 4'd0; tens = 4'd0; ones = 4'd0;
        team_sel = 1'b0; blink_en = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk_an("reset_an", 4'hF);
            chk_seg("reset_seg", 7'h00);
            chk_frame("reset_frame", 1'b0);
        end
        rst = 1'b0;
        n = 0;

        // Reset display is 0/0/0 with tag A: only ones and tag slots light
        goto(1);
        chk_an("r0_ones_an", 4'b1110);
        chk_seg("r0_ones_seg", 7'h3F);
        chk_frame("r0_no_frame", 1'b0);
        do_load(4'd1, 4'd2, 4'd3, 1'b0);
        goto(5);
        chk_an("old_tens_blank", 4'hF);
        goto(13);
        chk_an("old_tag_an", 4'b0111);
        chk_seg("old_tag_seg", 7'h77);
        goto(16);
        chk_an("old_persist", 4'b0111);
        goto(17);
        chk_an("new_ones_an", 4'b1110);
        chk_seg("new_ones_3", 7'h4F);
        chk_frame("frame_17", 1'b1);
        goto(18);
        chk_frame("frame_18", 1'b0);
        goto(21);
        chk_an("new_tens_an", 4'b1101);
        chk_seg("new_tens_2", 7'h5B);
        goto(25);
        chk_an("new_hund_an", 4'b1011);
        chk_seg("new_hund_1", 7'h06);
        goto(29);
        chk_an("new_tag_an", 4'b0111);
        chk_seg("new_tag_A", 7'h77);
        goto(33);
        chk_frame("frame_33", 1'b1);

        // 0/0/7 with tag b: hundreds and tens blanked
        goto(34);
        do_load(4'd0, 4'd0, 4'd7, 1'b1);
        goto(49);
        chk_an("z7_ones_an", 4'b1110);
        chk_seg("z7_ones_7", 7'h07);
        goto(53);
        chk_an("z7_tens_blank", 4'hF);
        goto(61);
        chk_an("z7_tag_an", 4'b0111);
        chk_seg("z7_tag_b", 7'h7C);
        goto(65);
        viol = 0; frames = 0;
        for (int i = 0; i < 16; i++) begin
            if (an[1] == 1'b0 || an[2] == 1'b0) viol++;
            if (an != 4'hF && $countones(~an) != 1) viol++;
            if (frame_start) frames++;
            goto(n + 1);
        end
        chk("z7_blank_viol", 8'(viol), 8'd0);
        chk("z7_frames", 8'(frames), 8'd1);

        // Out-of-range digit shows a dash; two loads in one frame, last wins
        do_load(4'd1, 4'hC, 4'd0, 1'b0);
        goto(101);
        chk_an("dash_an", 4'b1101);
        chk_seg("dash_seg", 7'h40);
        goto(102);
        do_load(4'd5, 4'd5, 4'd5, 1'b0);
        goto(105);
        chk_seg("no_tear_hund", 7'h06);
        goto(106);
        do_load(4'd9, 4'd9, 4'd9, 1'b0);
        goto(113);
        chk_an("last_ones_an", 4'b1110);
        chk_seg("last_ones_9", 7'h6F);
        goto(117);
        chk_seg("last_tens_9", 7'h6F);
        goto(121);
        chk_seg("last_hund_9", 7'h6F);

        // Blink: 8 ticks visible, 8 ticks dark
        goto(128);
        blink_en = 1'b1;
        goto(160);
        chk_an("blink_vis_end", 4'b0111);
        goto(161);
        chk_an("blink_off_start", 4'hF);
        offcnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (an == 4'hF) offcnt++;
            goto(n + 1);
        end
        chk("blink_off_cycles", 8'(offcnt), 8'd32);
        goto(240);
        chk_an("blink_off_240", 4'hF);
        blink_en = 1'b0;
        goto(241);
        chk_an("blink_drop_an", 4'b1110);
        chk_seg("blink_drop_seg", 7'h6F);

        // Load coinciding with the wrap tick is shown from the very next frame
        goto(253);
        chk_seg("prewrap_tag_A", 7'h77);
        goto(255);
        do_load(4'd2, 4'd4, 4'd6, 1'b1);
        goto(257);
        chk_an("wrapld_ones_an", 4'b1110);
        chk_seg("wrapld_ones_6", 7'h7D);
        goto(261);
        chk_seg("wrapld_tens_4", 7'h66);
        goto(265);
        chk_seg("wrapld_hund_2", 7'h5B);
        goto(269);
        chk_an("wrapld_tag_an", 4'b0111);
        chk_seg("wrapld_tag_b", 7'h7C);

        // Reset mid-frame with a pending load
        goto(275);
        do_load(4'd8, 4'd8, 4'd8, 1'b0);
        goto(280);
        rst = 1'b1;
        goto(281);
        chk_an("mid_rst_an", 4'hF);
        chk_seg("mid_rst_seg", 7'h00);
        chk_frame("mid_rst_frame", 1'b0);
        goto(282);
        rst = 1'b0;
        n = 0;
        goto(1);
        chk_an("post_rst_an", 4'b1110);
        chk_seg("post_rst_seg", 7'h3F);
        goto(17);
        chk_an("post_wrap_an", 4'b1110);
        chk_seg("post_wrap_no8", 7'h3F);
        chk_frame("post_wrap_frame", 1'b1);
        goto(21);
        chk_an("post_wrap_tens", 4'hF);
        goto(29);
        chk_seg("post_wrap_tag", 7'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
